// File: rtl/debug_port_master_pkg.sv
// Shared types and constants for the debug cache-port burst master.
package debug_port_master_pkg;

    // Burst engine states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RADDR = 3'd2,
        ST_RWAIT = 3'd3,
        ST_ROUT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Debug port targets.
    localparam logic TGT_DCACHE = 1'b0;
    localparam logic TGT_ICACHE = 1'b1;

    // Byte distance between consecutive words of a burst.
    localparam logic [31:0] WORD_STEP = 32'd4;

    // Clears the byte offset of a start address.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dbg_port_mux.sv
// Steers the registered debug access onto the selected cache port and
// returns that port's read data. The unselected port is held at zero.
module dbg_port_mux
    import debug_port_master_pkg::*;
(
    input  logic        target_i,
    input  logic [31:0] a2_i,
    input  logic [31:0] wd2_i,
    input  logic [3:0]  we2_i,
    output logic [31:0] dc_a2_o,
    output logic [31:0] dc_wd2_o,
    output logic [3:0]  dc_we2_o,
    output logic [31:0] ic_a2_o,
    output logic [31:0] ic_wd2_o,
    output logic [3:0]  ic_we2_o,
    input  logic [31:0] dc_rd2_i,
    input  logic [31:0] ic_rd2_i,
    output logic [31:0] rd2_o
);

    // Route the access to one side and pick that side's read data.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        dc_a2_o  = '0;
        dc_wd2_o = '0;
        dc_we2_o = '0;
        ic_a2_o  = '0;
        ic_wd2_o = '0;
        ic_we2_o = '0;
        rd2_o    = dc_rd2_i;
        if (target_i == TGT_DCACHE) begin
            dc_a2_o  = a2_i;
            dc_wd2_o = wd2_i;
            dc_we2_o = we2_i;
        end
        if (target_i == TGT_ICACHE) begin
            ic_a2_o  = a2_i;
            ic_wd2_o = wd2_i;
            ic_we2_o = we2_i;
            rd2_o    = ic_rd2_i;
        end
    end

endmodule

// File: rtl/debug_port_master.sv
// Host-side burst master for the core's data/instruction cache debug ports.
// One command becomes a burst of word writes or reads; the core is held in
// reset while a burst is in flight.
module debug_port_master
    import debug_port_master_pkg::*;
#(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned READ_LAT = 1
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_target,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_be,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,
    output logic             rdata_last,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             core_hold,
    output logic [31:0]      dc_a2,
    output logic [31:0]      dc_wd2,
    output logic [3:0]       dc_we2,
    input  logic [31:0]      dc_rd2,
    output logic [31:0]      ic_a2,
    output logic [31:0]      ic_wd2,
    output logic [3:0]       ic_we2,
    input  logic [31:0]      ic_rd2
);

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic [3:0]       be_q;
    logic             target_q;
    logic [2:0]       lat_q;
    logic [31:0]      a2_q;
    logic [31:0]      wd2_q;
    logic [3:0]       we2_q;
    logic [31:0]      rdata_q;
    logic             done_q;
    logic [31:0]      rd2;

    logic [31:0]      addr_inc_d;
    logic [LEN_W-1:0] cnt_dec_d;
    logic             last_word_d;

    assign addr_inc_d  = addr_q + WORD_STEP;
    assign cnt_dec_d   = cnt_q - LEN_W'(1);
    assign last_word_d = (cnt_q == LEN_W'(1));

    assign cmd_ready   = (state_q == ST_IDLE) && CPU_RST_N;
    assign busy        = (state_q != ST_IDLE);
    assign core_hold   = busy;
    assign wdata_ready = (state_q == ST_WRITE);
    assign rdata_valid = (state_q == ST_ROUT);
    assign rdata_last  = rdata_valid && last_word_d;
    assign rdata       = rdata_q;
    assign done        = done_q;

    // Burst sequencer: state, address/count/latency tracking and the
    // registered debug-port access.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            be_q     <= '0;
            target_q <= TGT_DCACHE;
            lat_q    <= '0;
            a2_q     <= '0;
            wd2_q    <= '0;
            we2_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the values from before this edge regardless of order.
            we2_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr & WORD_MASK;
                        cnt_q    <= cmd_len;
                        be_q     <= cmd_be;
                        target_q <= cmd_target;
                        if (cmd_len == '0)  state_q <= ST_DONE;
                        else if (cmd_write) state_q <= ST_WRITE;
                        else                state_q <= ST_RADDR;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                    end else if (wdata_valid) begin
                        a2_q   <= addr_q;
                        wd2_q  <= wdata;
                        we2_q  <= be_q;
                        addr_q <= addr_inc_d;
                        cnt_q  <= cnt_dec_d;
                        if (last_word_d) state_q <= ST_DONE;
                    end
                end
                ST_RADDR: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                    end else begin
                        a2_q    <= addr_q;
                        lat_q   <= 3'(READ_LAT);
                        state_q <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                        if (lat_q == 3'd1) begin
                            rdata_q <= rd2;
                            state_q <= ST_ROUT;
                        end
                    end
                end
                ST_ROUT: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                    end else if (rdata_ready) begin
                        addr_q  <= addr_inc_d;
                        cnt_q   <= cnt_dec_d;
                        state_q <= last_word_d ? ST_DONE : ST_RADDR;
                    end
                end
                ST_DONE: begin
                    a2_q    <= '0;
                    wd2_q   <= '0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dbg_port_mux u_mux (
        .target_i (target_q),
        .a2_i     (a2_q),
        .wd2_i    (wd2_q),
        .we2_i    (we2_q),
        .dc_a2_o  (dc_a2),
        .dc_wd2_o (dc_wd2),
        .dc_we2_o (dc_we2),
        .ic_a2_o  (ic_a2),
        .ic_wd2_o (ic_wd2),
        .ic_we2_o (ic_we2),
        .dc_rd2_i (dc_rd2),
        .ic_rd2_i (ic_rd2),
        .rd2_o    (rd2)
    );

endmodule

// File: tb/tb_debug_port_master.sv
// Self-checking bench for debug_port_master: directed scenarios plus random
// bursts, checked against a transaction-level model of the burst rules.
module tb_debug_port_master;

    localparam int LEN_W = 16;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready, cmd_write, cmd_target;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0]       cmd_be;
    logic             wdata_valid, wdata_ready;
    logic [31:0]      wdata;
    logic             rdata_valid, rdata_ready, rdata_last;
    logic [31:0]      rdata;
    logic             abort, busy, done, core_hold;
    logic [31:0]      dc_a2, dc_wd2, dc_rd2, ic_a2, ic_wd2, ic_rd2;
    logic [3:0]       dc_we2, ic_we2;

    // Cache models: asynchronous read, so data is valid one cycle after the
    // registered address (READ_LAT = 1). Index aliases on address bits [9:2].
    logic [31:0] dc_mem [256];
    logic [31:0] ic_mem [256];
    assign dc_rd2 = dc_mem[dc_a2[9:2]];
    assign ic_rd2 = ic_mem[ic_a2[9:2]];

    debug_port_master #(.LEN_W(LEN_W), .READ_LAT(1)) dut (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_target(cmd_target), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_be(cmd_be),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .abort(abort), .busy(busy), .done(done),
        .core_hold(core_hold),
        .dc_a2(dc_a2), .dc_wd2(dc_wd2), .dc_we2(dc_we2), .dc_rd2(dc_rd2),
        .ic_a2(ic_a2), .ic_wd2(ic_wd2), .ic_we2(ic_we2), .ic_rd2(ic_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;

    typedef struct {
        bit          tgt;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Port monitor: logs every write strobe and checks the other side is quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dc_we2 != 4'd0) begin
                wq.push_back('{tgt: 1'b0, a: dc_a2, d: dc_wd2, be: dc_we2, cyc: cyc});
                check("ic_quiet", {ic_a2 | ic_wd2, 28'd0, ic_we2}, 64'd0);
            end
            if (ic_we2 != 4'd0) begin
                wq.push_back('{tgt: 1'b1, a: ic_a2, d: ic_wd2, be: ic_we2, cyc: cyc});
                check("dc_quiet", {dc_a2 | dc_wd2, 28'd0, dc_we2}, 64'd0);
            end
            if (done) done_cnt++;
            if (rdata_valid) rv_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input bit tgt, input logic [31:0] a);
        return tgt ? ic_mem[a[9:2]] : dc_mem[a[9:2]];
    endfunction

    // Present a command and complete its handshake; returns in the cycle
    // after acceptance.
    task automatic issue(input bit wr, input bit tgt, input logic [31:0] addr,
                         input int len, input logic [3:0] be);
        int  w;
        bit  rdy;
        w = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_target = tgt;
        cmd_addr = addr; cmd_len = LEN_W'(len); cmd_be = be;
        rdy = cmd_ready;
        while (!rdy && w < 50) begin
            tick();
            rdy = cmd_ready;
            w++;
        end
        check("cmd_accept", rdy, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for the done pulse; check it is single, hold drops with it and
    // the port address has returned to zero.
    task automatic wait_done(input string tag, input int d0);
        int   w;
        logic ph;
        w = 0;
        ph = core_hold;
        while (done !== 1'b1 && w < 300) begin
            ph = core_hold;
            tick();
            w++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_hold_fall"}, {ph, core_hold}, 2'b10);
        check({tag, "_a2_zero"}, {dc_a2, ic_a2}, 64'd0);
        tick();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        check({tag, "_done_low"}, done, 0);
    endtask

    task automatic do_write(input bit tgt, input logic [31:0] addr, input int len,
                            input logic [3:0] be, input bit gaps,
                            input logic [31:0] words[$], input string tag);
        int k, budget, d0, rv0;
        bit rdy;
        wq.delete();
        d0 = done_cnt; rv0 = rv_cnt;
        issue(1'b1, tgt, addr, len, be);
        k = 0; budget = 0;
        while (k < len && budget < 500) begin
            wdata_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wdata = words[k];
            rdy = wdata_ready;
            tick();
            if (wdata_valid && rdy) k++;
            budget++;
        end
        wdata_valid = 1'b0;
        check({tag, "_wbudget"}, k, len);
        wait_done(tag, d0);
        check({tag, "_nwr"}, wq.size(), len);
        check({tag, "_no_rvalid"}, 32'(rv_cnt - rv0), 0);
        for (int i = 0; i < len && i < wq.size(); i++) begin
            logic [31:0] ea;
            ea = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            check({tag, "_tgt"}, wq[i].tgt, tgt);
            check({tag, "_a2"}, wq[i].a, ea);
            check({tag, "_wd2"}, wq[i].d, words[i]);
            check({tag, "_we2"}, wq[i].be, be);
        end
    endtask

    task automatic do_read(input bit tgt, input logic [31:0] addr, input int len,
                           input bit gaps, input int stall, input string tag);
        int          k, budget, d0;
        logic [31:0] r0, a0, ea;
        bit          stalled;
        wq.delete();
        d0 = done_cnt; stalled = 0;
        issue(1'b0, tgt, addr, len, 4'hF);
        k = 0; budget = 0;
        while (k < len && budget < 500) begin
            if (rdata_valid && k == 0 && stall > 0 && !stalled) begin
                r0 = rdata; a0 = tgt ? ic_a2 : dc_a2;
                rdata_ready = 1'b0;
                repeat (stall) begin
                    tick();
                    check({tag, "_bp_rdata"}, rdata, r0);
                    check({tag, "_bp_a2"}, tgt ? ic_a2 : dc_a2, a0);
                    check({tag, "_bp_valid"}, rdata_valid, 1);
                end
                stalled = 1;
            end
            rdata_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rdata_valid && rdata_ready) begin
                ea = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
                check({tag, "_rdata"}, rdata, mem_rd(tgt, ea));
                check({tag, "_last"}, rdata_last, (k == len - 1));
                k++;
            end
            tick();
            budget++;
        end
        rdata_ready = 1'b0;
        check({tag, "_rbudget"}, k, len);
        wait_done(tag, d0);
        check({tag, "_no_we2"}, wq.size(), 0);
    endtask

    initial begin
        logic [31:0] words[$];
        int          d0, rv0, w, len;
        bit          wr, tgt;
        logic [31:0] a;
        logic [3:0]  be;

        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_target = 0; cmd_addr = '0;
        cmd_len = '0; cmd_be = '0; wdata_valid = 0; wdata = '0;
        rdata_ready = 0; abort = 0;
        for (int i = 0; i < 256; i++) begin
            dc_mem[i] = $urandom;
            ic_mem[i] = $urandom;
        end
        dc_mem[8'h40] = 32'h0000_00A0;
        dc_mem[8'h41] = 32'h0000_00B1;

        // Reset state.
        #2;
        check("rst_ctrl", {cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, done, core_hold}, 0);
        check("rst_dc", {dc_a2, dc_wd2}, 0);
        check("rst_ic", {ic_a2, ic_wd2}, 0);
        check("rst_we_rd", {24'd0, dc_we2, ic_we2, rdata}, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {cmd_ready, busy}, 2'b10);

        // Instruction-cache write burst, back-to-back data.
        words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};
        do_write(1'b1, 32'h0000_0003, 3, 4'hF, 1'b0, words, "ic_wr");
        if (wq.size() == 3) begin
            check("ic_wr_b2b_1", 32'(wq[1].cyc - wq[0].cyc), 1);
            check("ic_wr_b2b_2", 32'(wq[2].cyc - wq[1].cyc), 1);
        end

        // Data-cache read burst.
        do_read(1'b0, 32'h0000_0100, 2, 1'b0, 0, "dc_rd");

        // Read backpressure.
        do_read(1'b0, 32'h0000_0100, 2, 1'b0, 5, "rd_bp");

        // Zero-length write and read.
        for (int z = 0; z < 2; z++) begin
            wq.delete();
            d0 = done_cnt; rv0 = rv_cnt;
            issue(z == 0, 1'b0, 32'h0000_0020, 0, 4'hF);
            check("zl_done_c1", {done, busy}, 2'b01);
            tick();
            check("zl_done_c2", {done, busy}, 2'b10);
            tick();
            check("zl_done_once", 32'(done_cnt - d0), 1);
            check("zl_no_access", {wq.size(), 32'(rv_cnt - rv0)}, 0);
        end

        // Address wrap-around.
        words = '{32'h1111_2222, 32'h3333_4444};
        do_write(1'b0, 32'hFFFF_FFFC, 2, 4'h5, 1'b0, words, "wrap");

        // Abort together with the second of four writes.
        wq.delete();
        d0 = done_cnt;
        issue(1'b1, 1'b0, 32'h0000_0040, 4, 4'hF);
        wdata_valid = 1'b1; wdata = 32'hAAAA_0001;
        tick();
        wdata = 32'hAAAA_0002; abort = 1'b1;
        tick();
        abort = 1'b0; wdata_valid = 1'b0;
        wait_done("abort_wr", d0);
        check("abort_wr_n", wq.size(), 1);
        if (wq.size() >= 1) check("abort_wr_d", {wq[0].a, wq[0].d}, {32'h0000_0040, 32'hAAAA_0001});

        // Abort while read data is pending.
        d0 = done_cnt;
        issue(1'b0, 1'b0, 32'h0000_0200, 3, 4'hF);
        w = 0;
        while (!rdata_valid && w < 20) begin tick(); w++; end
        check("abort_rd_valid", rdata_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_drop", rdata_valid, 0);
        wait_done("abort_rd", d0);

        // Random bursts with random stream gaps.
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            tgt = 1'($urandom_range(0, 1));
            a   = $urandom;
            len = $urandom_range(0, 5);
            be  = 4'($urandom_range(1, 15));
            if (wr) begin
                words.delete();
                for (int i = 0; i < len; i++) words.push_back($urandom);
                do_write(tgt, a, len, be, 1'b1, words, "rnd_wr");
            end else begin
                do_read(tgt, a, len, 1'b1, 0, "rnd_rd");
            end
        end

        // Reset asserted while waiting on read data.
        issue(1'b0, 1'b0, 32'h0000_0100, 3, 4'hF);
        tick();
        check("rw_a2", dc_a2, 32'h0000_0100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, done, core_hold}, 0);
        check("mid_rst_dc", {dc_a2, dc_wd2}, 0);
        check("mid_rst_ic", {ic_a2, ic_wd2}, 0);
        check("mid_rst_we_rd", {24'd0, dc_we2, ic_we2, rdata}, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rel_ready", {cmd_ready, busy}, 2'b10);
        do_read(1'b0, 32'h0000_0104, 1, 1'b0, 0, "post_rst_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_port_master.md
Name: debug_port_master

Overview:
- Host-side initiator for the core's debug cache ports: drives the data-cache and instruction-cache debug address, write-data and byte-enable inputs, and collects their read data.
- Turns one command (target, start address, word count, direction) into a burst of word accesses, with valid/ready streams for write data and read data.
- Sits between a host link (UART/JTAG bridge) and the core top.
- Holds the core in reset while a burst is in progress, so program and data images load safely.

Parameters:
- LEN_W, 16, width of the word-count field; maximum burst is 2^LEN_W-1 words.
- READ_LAT, 1, cycles from a registered debug address until the matching RD2 is valid; legal range 1..4.

Ports:
- CPU_CLK  in  1  clock.
- CPU_RST_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid and ready are both high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_target  in  1  0 = data cache, 1 = instruction cache.
- cmd_addr  in  32  start byte address; bits [1:0] are ignored (forced to 0).
- cmd_len  in  LEN_W  number of words.
- cmd_be  in  4  byte enables applied to every write of the burst.
- wdata_valid / wdata_ready  in/out  1/1  write-data stream handshake.
- wdata  in  32  write word.
- rdata_valid / rdata_ready  out/in  1/1  read-data stream handshake.
- rdata  out  32  read word.
- rdata_last  out  1  marks the final word of a read burst.
- abort  in  1  synchronous burst cancel.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a burst completes or is aborted.
- core_hold  out  1  active-high reset request to the core; equals busy.
- dc_a2 / dc_wd2 / dc_we2  out  32/32/4  data-cache debug address, write data, byte enables.
- dc_rd2  in  32  data-cache debug read data.
- ic_a2 / ic_wd2 / ic_we2  out  32/32/4  instruction-cache debug address, write data, byte enables.
- ic_rd2  in  32  instruction-cache debug read data.

Behaviour:
- Reset:
  - All outputs are 0, including cmd_ready, busy and every we2.
  - State is IDLE; the address, count and latency registers are cleared.
  - Reset asserted mid-burst clears everything immediately, with no write glitch.
- Registered outputs: all debug-port outputs. The selected target's a2/wd2/we2 update; the other target's outputs stay 0. we2 is nonzero for exactly one cycle per accepted word.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch addr = {cmd_addr[31:2],2'b00}, cnt = cmd_len, be, write, target.
  - If cmd_len = 0: go to DONE without any port access.
  - Otherwise go to WRITE or RADDR.
- WRITE:
  - wdata_ready = 1.
  - On each wdata handshake, register a2 = addr, wd2 = wdata, we2 = be; then addr += 4 (wraps 0xFFFFFFFC -> 0x00000000) and cnt -= 1.
  - When cnt reaches 0, go to DONE. One word per cycle is sustained.
  - Cycles without a handshake drive we2 = 0.
- RADDR: register a2 = addr with we2 = 0, load the latency counter with READ_LAT, go to RWAIT.
- RWAIT:
  - Decrement the latency counter.
  - When it expires, capture the selected rd2 into rdata and go to ROUT.
  - a2 is held stable throughout.
- ROUT:
  - rdata_valid = 1; rdata_last = (cnt == 1).
  - rdata stays stable until the handshake.
  - On handshake: addr += 4, cnt -= 1; go to DONE if cnt becomes 0, else RADDR.
  - Read throughput is one word per READ_LAT+2 cycles; this is accepted.
- DONE: done = 1 for one cycle, a2 returns to 0, next state IDLE. busy stays high during DONE.
- abort:
  - Honoured in WRITE, RADDR, RWAIT and ROUT.
  - The next state is DONE. No further we2 is issued, and any pending rdata is dropped (rdata_valid goes low).
  - If abort and wdata_valid arrive in the same WRITE cycle, abort wins and no write is issued.
  - abort is ignored in IDLE and DONE.
- Concurrency: a new command is never accepted while busy. cmd_ready is combinational: (state == IDLE) and reset is released.
- core_hold: high from the cycle after command acceptance through DONE inclusive.

Decomposition:
- Shared package holds:
  - state encoding IDLE/WRITE/RADDR/RWAIT/ROUT/DONE (3 bits);
  - target constants TGT_DCACHE = 0 and TGT_ICACHE = 1;
  - word-step constant 4.
- One natural sub-module: dbg_port_mux. It steers the registered a2/wd2/we2 to the dc_* or ic_* outputs, zeroes the unselected side, and selects dc_rd2 or ic_rd2.
- The FSM, counters and stream logic stay in the top module.

Test Plan:
- Write burst to instruction cache: target = 1, addr = 0x00000003, len = 3, be = 0xF, wdata 0x00000013, 0x00100093, 0x00208113 presented back-to-back -> ic_a2 = 0, 4, 8 on consecutive cycles with ic_we2 = 0xF each; dc_we2 stays 0; done pulses once; core_hold falls the cycle after DONE.
- Read burst from data cache with a READ_LAT = 1 memory model preloaded with 0xA0, 0xB1 at 0x100 and 0x104 -> rdata 0xA0 then 0xB1; rdata_last is high only on 0xB1.
- Read backpressure: rdata_ready held low for 5 cycles -> rdata and dc_a2 stay constant and no new address is issued.
- Zero length: len = 0 -> no we2, no rdata_valid; done pulses 2 cycles after acceptance.
- Wrap-around: write addr = 0xFFFFFFFC, len = 2 -> a2 = 0xFFFFFFFC then 0x00000000.
- Abort and reset:
  - Abort in the cycle of the 2nd of 4 writes -> only 1 we2 pulse, then done.
  - CPU_RST_N low during RWAIT -> all outputs 0 immediately; cmd_ready = 1 after release.
